posit_result_fifo: RTL and testbench
====================================

# posit_result_fifo

Per-operation result queue placed directly downstream of each pipelined posit arithmetic unit (add, mul, div) in the posit coprocessor. It captures every `done` pulse's result and flags into a circular buffer. It serves decoded bus read requests in FIFO order. A read that arrives while the queue is empty is held as a pending request and answered as soon as a result lands. Overflow is reported instead of silently corrupting data.

## Interface
- `DATA_W`, default 32: width of a posit result word.
- `DEPTH`, default 32: number of entries. Must be a power of two, ≥ 2.
- `PTR_W`, default `$clog2(DEPTH)`: pointer width. Derived; not overridden.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `push_i`  in  1  result-valid pulse from the posit unit's `done`.
- `push_data_i`  in  DATA_W  result word; sampled when `push_i`=1.
- `push_inf_i`  in  1  unit `inf` flag; sampled with the data.
- `push_zero_i`  in  1  unit `zero` flag; sampled with the data.
- `rd_req_i`  in  1  decoded bus read for this queue; single-cycle pulse.
- `clear_i`  in  1  synchronous flush.
- `rvalid_o`  out  1  one-cycle response strobe.
- `rdata_o`  out  DATA_W  head result. Zero whenever `rvalid_o`=0.
- `rflags_o`  out  2  {inf, zero} of the returned entry. Zero whenever `rvalid_o`=0.
- `pending_o`  out  1  a read is waiting on an empty queue.
- `count_o`  out  PTR_W+1  occupancy, 0..DEPTH.
- `empty_o`  out  1  `count_o`==0.
- `full_o`  out  1  `count_o`==DEPTH.
- `overflow_o`  out  1  sticky: a push was dropped.

## Operation
- Storage: DEPTH entries of DATA_W+2 bits. Write pointer `wp`, read pointer `rp`, counter `cnt`.
  - Pointers wrap modulo DEPTH, from DEPTH-1 to 0.
  - `cnt` is kept explicitly, so full and empty are unambiguous.
- Push:
  - If `push_i` and not full, write {inf, zero, data} at `wp`, then `wp`+1.
  - If `push_i` and full with no pop in the same cycle, drop the entry. Set `overflow_o`=1. Leave the stored contents untouched.
- Read FSM, two states:
  - IDLE:
    - `rd_req_i` with `cnt`>0: pop the head. Register it to `rdata_o`/`rflags_o`, pulse `rvalid_o` next cycle, `rp`+1. Stay in IDLE.
    - `rd_req_i` with `cnt`==0: go to WAIT and set `pending_o`=1.
  - WAIT:
    - When `cnt`>0: pop the head, pulse `rvalid_o` next cycle, clear `pending_o`, return to IDLE.
    - `rd_req_i` received in WAIT is ignored. Exactly one response is produced for the outstanding request.
- Simultaneous push and pop in one cycle:
  - Both take effect and `cnt` is unchanged.
  - This applies when full: the pop frees the slot, the push is accepted, no overflow.
- Push with `cnt`==0 in the same cycle as `rd_req_i`: no bypass. The read goes to WAIT and is served on the following cycle.
- `clear_i`:
  - Sets `wp`=`rp`=`cnt`=0, FSM to IDLE, `pending_o`=0, `overflow_o`=0.
  - Overrides any push or read in the same cycle; `rvalid_o`=0 next cycle.
  - Entry contents need not be cleared.
- Reset (asynchronous, any time, including while in WAIT):
  - All pointers, `cnt` and FSM return to IDLE/0.
  - Outputs: `rvalid_o`=0, `rdata_o`=0, `rflags_o`=0, `pending_o`=0, `count_o`=0, `empty_o`=1, `full_o`=0, `overflow_o`=0.

## Timing
- Read on a non-empty queue: `rd_req_i` in cycle t gives `rvalid_o`=1 with data in cycle t+1.
- Read on an empty queue: the first push at cycle p gives `rvalid_o` at p+2.
  - This holds both when p is the request cycle and when p is later.
- `pending_o` rises in t+1 after an empty-queue read. It falls in the cycle `rvalid_o` asserts.
- `count_o`, `empty_o` and `full_o` are registered and reflect all pushes/pops of the previous edge.
- `overflow_o` asserts the cycle after the dropped push.
- `rvalid_o` never asserts on two consecutive cycles unless `rd_req_i` did.

## Test plan
- Push 0x3F800000, 0x40000000, 0x40400000 with inf/zero=0, then three reads → `rvalid_o` pulses with the data in the same order, one cycle after each request. `count_o` goes 3,2,1,0 and `empty_o`=1.
- `rd_req_i` on an empty queue at t, push 0x12345678 at t+3 → `pending_o`=1 over t+1..t+4. `rvalid_o`=1 with 0x12345678 at t+5. `pending_o`=0 from t+5.
- Fill 32 entries (values 1..32), push 33 → `full_o`=1, `overflow_o`=1. Then 32 reads return 1..32, wrapping the pointer through index 0.
- With the queue full, push 0xAA in the same cycle as a read → the read returns the oldest entry. `count_o` stays 32, `overflow_o` stays 0, and 0xAA is the last entry read back.
- Push an entry with push_inf_i=1 (data 0x80000000), then with push_zero_i=1 (data 0) → `rflags_o`=2'b10, then 2'b01, on the respective reads.
- With 5 entries and a pending-free queue, assert `clear_i` together with `rd_req_i`; separately, drop `rst_ni` while in WAIT → after the clear, `rvalid_o`=0 and `count_o`=0. After reset, all outputs take their reset values and no late `rvalid_o` appears.

Source files
------------

// File: rtl/posit_result_fifo.sv
// Result queue behind a pipelined posit unit: buffers {inf, zero, data} per done
// pulse and answers bus reads in order, parking a read that arrives on an empty queue.
module posit_result_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              push_inf_i,
    input  logic              push_zero_i,
    input  logic              rd_req_i,
    input  logic              clear_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        rflags_o,
    output logic              pending_o,
    output logic [PTR_W:0]    count_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              overflow_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_W+1:0] mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  wp_q, wp_d;
    logic [PTR_W-1:0]  rp_q, rp_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rflags_q, rflags_d;

    logic              pop;
    logic              push_acc;
    logic              have_data;
    logic              is_full;
    logic [DATA_W+1:0] head;

    assign have_data = (cnt_q != '0);
    assign is_full   = (cnt_q == CNT_FULL);
    assign head      = mem_q[rp_q];

    always_comb begin
        state_d  = state_q;
        wp_d     = wp_q;
        rp_d     = rp_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        rvalid_d = 1'b0;
        rdata_d  = '0;
        rflags_d = '0;
        pop      = 1'b0;
        push_acc = 1'b0;

        if (clear_i) begin
            state_d = ST_IDLE;
            wp_d    = '0;
            rp_d    = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rd_req_i) begin
                        if (have_data) pop = 1'b1;
                        else           state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Further requests are ignored here; one answer per parked read.
                    if (have_data) begin
                        pop     = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // A pop in the same cycle frees the slot, so a full queue still accepts.
            push_acc = push_i && (!is_full || pop);
            if (push_i && !push_acc) ovf_d = 1'b1;

            if (pop) begin
                rvalid_d = 1'b1;
                rdata_d  = head[DATA_W-1:0];
                rflags_d = head[DATA_W+1:DATA_W];
                rp_d     = rp_q + PTR_ONE;
            end
            if (push_acc) wp_d = wp_q + PTR_ONE;

            if (push_acc && !pop)      cnt_d = cnt_q + CNT_ONE;
            else if (pop && !push_acc) cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rflags_q <= '0;
        end else begin
            state_q  <= state_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rflags_q <= rflags_d;
        end
    end

    // Storage carries no reset; occupancy alone defines which entries are live.
    always_ff @(posedge clk_i) begin
        if (push_acc) mem_q[wp_q] <= {push_inf_i, push_zero_i, push_data_i};
    end

    assign rvalid_o   = rvalid_q;
    assign rdata_o    = rdata_q;
    assign rflags_o   = rflags_q;
    assign pending_o  = (state_q == ST_WAIT);
    assign count_o    = cnt_q;
    assign empty_o    = (cnt_q == '0);
    assign full_o     = is_full;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_posit_result_fifo.sv
// Bench for posit_result_fifo: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model.
module tb_posit_result_fifo;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int PTR_W  = $clog2(DEPTH);

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              push_i = 1'b0;
    logic [DATA_W-1:0] push_data_i = '0;
    logic              push_inf_i = 1'b0;
    logic              push_zero_i = 1'b0;
    logic              rd_req_i = 1'b0;
    logic              clear_i = 1'b0;
    logic              rvalid_o;
    logic [DATA_W-1:0] rdata_o;
    logic [1:0]        rflags_o;
    logic              pending_o;
    logic [PTR_W:0]    count_o;
    logic              empty_o;
    logic              full_o;
    logic              overflow_o;

    posit_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .push_i(push_i), .push_data_i(push_data_i),
        .push_inf_i(push_inf_i), .push_zero_i(push_zero_i),
        .rd_req_i(rd_req_i), .clear_i(clear_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rflags_o(rflags_o),
        .pending_o(pending_o), .count_o(count_o), .empty_o(empty_o),
        .full_o(full_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of {inf, zero, data} plus a parked-read flag.
    logic [DATA_W+1:0] exp_q[$];
    bit                m_wait = 1'b0;
    bit                m_ovf  = 1'b0;
    bit                m_rv   = 1'b0;
    logic [DATA_W-1:0] m_rdata = '0;
    logic [1:0]        m_rflags = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("rvalid",   64'(rvalid_o),   64'(m_rv));
        check("rdata",    64'(rdata_o),    64'(m_rdata));
        check("rflags",   64'(rflags_o),   64'(m_rflags));
        check("pending",  64'(pending_o),  64'(m_wait));
        check("count",    64'(count_o),    64'(exp_q.size()));
        check("empty",    64'(empty_o),    64'(exp_q.size() == 0));
        check("full",     64'(full_o),     64'(exp_q.size() == DEPTH));
        check("overflow", 64'(overflow_o), 64'(m_ovf));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_wait = 1'b0; m_ovf = 1'b0; m_rv = 1'b0; m_rdata = '0; m_rflags = '0;
    endtask

    task automatic model_step();
        int sz;
        bit serve;
        logic [DATA_W+1:0] item;
        sz = exp_q.size();
        m_rv = 1'b0; m_rdata = '0; m_rflags = '0;
        if (clear_i) begin
            exp_q.delete();
            m_wait = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            serve = (m_wait || rd_req_i) && (sz > 0);
            if (serve) begin
                item     = exp_q.pop_front();
                m_rv     = 1'b1;
                m_rdata  = item[DATA_W-1:0];
                m_rflags = item[DATA_W+1:DATA_W];
                m_wait   = 1'b0;
            end else if (rd_req_i && sz == 0) begin
                m_wait = 1'b1;
            end
            if (push_i) begin
                if (sz < DEPTH || serve) exp_q.push_back({push_inf_i, push_zero_i, push_data_i});
                else                     m_ovf = 1'b1;
            end
        end
    endtask

    task automatic cycle(input bit p, input logic [DATA_W-1:0] d, input bit inf, input bit zero,
                         input bit rd, input bit clr);
        push_i = p; push_data_i = d; push_inf_i = inf; push_zero_i = zero;
        rd_req_i = rd; clear_i = clr;
        @(posedge clk_i);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset values
        #12;
        check_all();
        check("rst_empty", 64'(empty_o), 64'd1);
        rst_ni = 1'b1;
        idle(1);

        // In-order reads of three results
        cycle(1'b1, 32'h3F800000, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("cnt3", 64'(count_o), 64'd3);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("rd0", 64'(rdata_o), 64'h3F800000);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("rd2", 64'(rdata_o), 64'h40400000);
        check("cnt0", 64'(count_o), 64'd0);

        // Parked read served two cycles after the late push
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("pend_t1", 64'(pending_o), 64'd1);
        idle(2);
        cycle(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pend_t4", 64'(pending_o), 64'd1);
        idle(1);
        check("late_rvalid", 64'(rvalid_o), 64'd1);
        check("late_rdata", 64'(rdata_o), 64'h12345678);
        check("late_pend", 64'(pending_o), 64'd0);
        idle(1);

        // Push in the request cycle of an empty-queue read
        cycle(1'b1, 32'hCAFE0001, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Fill, overflow, drain with pointer wrap
        for (int i = 1; i <= 33; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        check("fill_full", 64'(full_o), 64'd1);
        check("fill_ovf", 64'(overflow_o), 64'd1);
        for (int i = 1; i <= 32; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("drain_last", 64'(rdata_o), 64'd32);

        // Push and pop together while full
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) cycle(1'b1, DATA_W'(100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
        check("pp_cnt", 64'(count_o), 64'd32);
        check("pp_ovf", 64'(overflow_o), 64'd0);
        check("pp_data", 64'(rdata_o), 64'd100);
        for (int i = 0; i < 32; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("pp_last", 64'(rdata_o), 64'hAA);

        // Flags
        cycle(1'b1, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("flag_inf", 64'(rflags_o), 64'd2);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("flag_zero", 64'(rflags_o), 64'd1);

        // Clear beats a read
        for (int i = 0; i < 5; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("clr_rvalid", 64'(rvalid_o), 64'd0);
        check("clr_cnt", 64'(count_o), 64'd0);

        // Asynchronous reset while a read is parked
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2 rst_ni = 1'b0;
        #1 model_reset();
        check_all();
        check("rst_pend", 64'(pending_o), 64'd0);
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        cycle(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Random traffic alternating fill-heavy and drain-heavy phases
        for (int ph = 0; ph < 8; ph++) begin
            for (int i = 0; i < 250; i++) begin
                bit p, rd, clr;
                p   = (ph % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
                rd  = (ph % 2 == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
                clr = ($urandom_range(0, 99) == 0);
                cycle(p, $urandom, 1'($urandom), 1'($urandom), rd, clr);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end
endmodule
